// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding and default widths.
package fetch_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC -> program memory request/ack -> IR -> decoder valid/ready.
// Jumps reload the PC and flush any fetch still waiting on memory.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_enable,
   output logic              pc_ld,
   output logic [ADDR_W-1:0] pc_load_val,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] ir_out,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              jump_req,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic              halt
);

   state_e              state_q, state_d;
   logic                flush_q, flush_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   ir_out_q, ir_out_d;
   logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
   logic                ir_valid_q, ir_valid_d;
   logic                pc_en_q, pc_en_d;
   logic                pc_ld_q, pc_ld_d;
   logic [ADDR_W-1:0]   pc_load_val_q, pc_load_val_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         flush_q       <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         ir_out_q      <= '0;
         ir_pc_q       <= '0;
         ir_valid_q    <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_ld_q       <= 1'b0;
         pc_load_val_q <= '0;
      end else begin
         state_q       <= state_d;
         flush_q       <= flush_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         ir_out_q      <= ir_out_d;
         ir_pc_q       <= ir_pc_d;
         ir_valid_q    <= ir_valid_d;
         pc_en_q       <= pc_en_d;
         pc_ld_q       <= pc_ld_d;
         pc_load_val_q <= pc_load_val_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      flush_d       = flush_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      ir_out_d      = ir_out_q;
      ir_pc_d       = ir_pc_q;
      ir_valid_d    = ir_valid_q;
      pc_en_d       = 1'b0;
      pc_ld_d       = 1'b0;
      pc_load_val_d = pc_load_val_q;
      if (jump_req) begin
         pc_ld_d       = 1'b1;
         pc_load_val_d = jump_addr;
         if (state_q == ST_WAIT) begin
            // An outstanding request is never abandoned; its ack is swallowed instead.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               flush_d   = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               flush_d = 1'b1;
            end
         end else begin
            ir_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: if (!halt) state_d = ST_REQ;
            ST_REQ: begin
               mem_addr_d = pc_in;
               mem_req_d  = 1'b1;
               state_d    = ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  mem_req_d = 1'b0;
                  if (flush_q) begin
                     flush_d = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     ir_out_d   = mem_data;
                     ir_pc_d    = mem_addr_q;
                     ir_valid_d = 1'b1;
                     pc_en_d    = 1'b1;
                     state_d    = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (ir_ready) begin
                  ir_valid_d = 1'b0;
                  state_d    = halt ? ST_IDLE : ST_REQ;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pc_enable   = pc_en_q;
   assign pc_ld       = pc_ld_q;
   assign pc_load_val = pc_load_val_q;
   assign mem_addr    = mem_addr_q;
   assign mem_req     = mem_req_q;
   assign ir_out      = ir_out_q;
   assign ir_pc       = ir_pc_q;
   assign ir_valid    = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit with a program_counter model and a ROM of programmable ack latency.
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pc_in;
   logic       pc_enable, pc_ld;
   logic [7:0] pc_load_val, mem_addr;
   logic       mem_req, mem_ack;
   logic [7:0] mem_data, ir_out, ir_pc;
   logic       ir_valid;
   logic       ir_ready = 1'b1;
   logic       jump_req = 1'b0;
   logic [7:0] jump_addr = 8'h00;
   logic       halt = 1'b0;

   logic [7:0] rom [256];
   int         lat = 2;
   int         cnt;
   logic       force_ack = 1'b0;
   logic [7:0] pc;

   int errors = 0, checks = 0;
   int en_cnt = 0, vrise_cnt = 0, viol_cnt = 0;
   logic v_prev = 1'b0;

   fetch_unit #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_enable(pc_enable), .pc_ld(pc_ld),
      .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
      .mem_data(mem_data), .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid),
      .ir_ready(ir_ready), .jump_req(jump_req), .jump_addr(jump_addr), .halt(halt)
   );

   always #5 clk = ~clk;

   // program_counter model: load beats increment, wraps at 8 bits
   always @(posedge clk) begin
      if (reset)          pc <= 8'h00;
      else if (pc_ld)     pc <= pc_load_val;
      else if (pc_enable) pc <= pc + 8'h01;
   end
   assign pc_in = pc;

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) cnt <= 0;
      else                              cnt <= cnt + 1;
   end
   assign mem_ack  = force_ack | (mem_req && (cnt == lat));
   assign mem_data = force_ack ? 8'hEE : rom[mem_addr];

   always @(posedge clk) begin
      if (!reset) begin
         if (pc_enable)            en_cnt    <= en_cnt + 1;
         if (pc_enable && pc_ld)   viol_cnt  <= viol_cnt + 1;
         if (ir_valid && !v_prev)  vrise_cnt <= vrise_cnt + 1;
      end
      v_prev <= ir_valid;
   end

   typedef struct {
      int         lat;
      logic [7:0] jaddr;
      logic [7:0] data;
      logic [7:0] exp_ir;
      logic [7:0] exp_next;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      jump_req = 1'b0; halt = 1'b0; force_ack = 1'b0;
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int n, output bit ok);
      n = 0; ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         cyc(); n++;
         if (ir_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_req_rise(input int bound, output bit ok);
      logic prev;
      prev = mem_req; ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         cyc();
         if (mem_req && !prev) begin ok = 1'b1; break; end
         prev = mem_req;
      end
   endtask

   initial begin
      int n, e0, v0, bad;
      bit ok;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;

      // reset, single fetch with latency 2
      rom[0] = 8'hA5; lat = 2;
      reset = 1'b1; cyc(); cyc();
      chk("reset_outputs", {ir_out, ir_pc, mem_addr, pc_load_val, ir_valid, mem_req, pc_enable, pc_ld},
          32'h0);
      reset = 1'b0;
      wait_valid(20, n, ok);  chk("t1_valid_seen", ok, 1);
      chk("t1_ir_out", ir_out, 8'hA5);
      chk("t1_ir_pc", ir_pc, 8'h00);
      chk("t1_pc_en_pulse", pc_enable, 1);
      cyc();
      chk("t1_pc_en_single", pc_enable, 0);
      wait_req_rise(20, ok);  chk("t1_req_seen", ok, 1);
      chk("t1_next_addr", mem_addr, 8'h01);

      // decoder backpressure with zero-latency memory, then 1-per-3 throughput
      rom[0] = 8'h10; rom[1] = 8'h11; rom[2] = 8'h12; rom[3] = 8'h13;
      lat = 0; ir_ready = 1'b0;
      do_reset();
      wait_valid(20, n, ok);  chk("t2_valid_seen", ok, 1);
      chk("t2_ir_out0", ir_out, 8'h10);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (ir_out !== 8'h10 || ir_valid !== 1'b1 || mem_req !== 1'b0) bad++;
      end
      chk("t2_hold_stable", bad, 0);
      ir_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_valid(20, n, ok);
         chk("t2_valid_seen_k", ok, 1);
         chk("t2_cycles_between", n, 3);
         chk("t2_ir_out_k", ir_out, 8'h10 + k);
         chk("t2_ir_pc_k", ir_pc, k);
      end

      // table: jump to target, fetch there, check latency and following address
      vecs[0] = '{0, 8'h40, 8'h3C, 8'h3C, 8'h41};
      vecs[1] = '{1, 8'hFF, 8'h5A, 8'h5A, 8'h00};
      vecs[2] = '{2, 8'h80, 8'hC3, 8'hC3, 8'h81};
      vecs[3] = '{3, 8'h00, 8'h96, 8'h96, 8'h01};
      foreach (vecs[i]) rom[vecs[i].jaddr] = vecs[i].data;
      do_reset();
      foreach (vecs[i]) begin
         lat = vecs[i].lat;
         jump_req = 1'b1; jump_addr = vecs[i].jaddr;
         cyc();
         jump_req = 1'b0;
         chk("tab_pc_ld", pc_ld, 1);
         chk("tab_load_val", pc_load_val, vecs[i].jaddr);
         wait_req_rise(30, ok);  chk("tab_req_seen", ok, 1);
         chk("tab_fetch_addr", mem_addr, vecs[i].jaddr);
         wait_valid(20, n, ok);  chk("tab_valid_seen", ok, 1);
         chk("tab_latency", n, vecs[i].lat + 1);
         chk("tab_ir_out", ir_out, vecs[i].exp_ir);
         chk("tab_ir_pc", ir_pc, vecs[i].jaddr);
         wait_req_rise(20, ok);  chk("tab_next_seen", ok, 1);
         chk("tab_next_addr", mem_addr, vecs[i].exp_next);
      end

      // jump while waiting on memory at PC 0x02
      rom[0] = 8'h10; rom[1] = 8'h11; rom[2] = 8'h12; rom[8'h18] = 8'h77;
      lat = 3;
      do_reset();
      wait_valid(20, n, ok);  chk("t3_v0", ok, 1);
      wait_valid(20, n, ok);  chk("t3_v1", ok, 1);
      wait_req_rise(20, ok);  chk("t3_req2", ok, 1);
      chk("t3_addr2", mem_addr, 8'h02);
      e0 = en_cnt; v0 = vrise_cnt;
      jump_req = 1'b1; jump_addr = 8'h18;
      cyc();
      jump_req = 1'b0;
      chk("t3_pc_ld", pc_ld, 1);
      chk("t3_load_val", pc_load_val, 8'h18);
      chk("t3_no_pc_en", pc_enable, 0);
      chk("t3_req_held", mem_req, 1);
      cyc();
      chk("t3_pc_ld_single", pc_ld, 0);
      wait_req_rise(30, ok);  chk("t3_req_seen", ok, 1);
      chk("t3_no_enable", en_cnt - e0, 0);
      chk("t3_no_valid", vrise_cnt - v0, 0);
      chk("t3_pc", pc, 8'h18);
      chk("t3_next_addr", mem_addr, 8'h18);
      wait_valid(20, n, ok);  chk("t3_valid_seen", ok, 1);
      chk("t3_ir_out", ir_out, 8'h77);
      chk("t3_ir_pc", ir_pc, 8'h18);

      // jump in the same cycle as the memory ack
      lat = 1;
      do_reset();
      wait_req_rise(20, ok);  chk("t4_req_seen", ok, 1);
      cyc();
      e0 = en_cnt; v0 = vrise_cnt;
      jump_req = 1'b1; jump_addr = 8'h18;
      cyc();
      jump_req = 1'b0;
      chk("t4_pc_ld", pc_ld, 1);
      chk("t4_ir_valid", ir_valid, 0);
      chk("t4_pc_en", pc_enable, 0);
      wait_req_rise(20, ok);  chk("t4_req2_seen", ok, 1);
      chk("t4_no_enable", en_cnt - e0, 0);
      chk("t4_no_valid", vrise_cnt - v0, 0);
      chk("t4_pc", pc, 8'h18);
      chk("t4_next_addr", mem_addr, 8'h18);

      // halt raised while waiting on memory
      lat = 2;
      do_reset();
      wait_req_rise(20, ok);  chk("t5_req_seen", ok, 1);
      halt = 1'b1;
      wait_valid(20, n, ok);  chk("t5_valid_seen", ok, 1);
      chk("t5_ir_out", ir_out, 8'h10);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (mem_req !== 1'b0) bad++;
      end
      chk("t5_no_req_halted", bad, 0);
      halt = 1'b0;
      wait_req_rise(10, ok);  chk("t5_resume_seen", ok, 1);
      chk("t5_resume_addr", mem_addr, 8'h01);

      // reset during WAIT, stray ack one cycle later
      lat = 3;
      do_reset();
      wait_valid(20, n, ok);  chk("t6_v0", ok, 1);
      wait_req_rise(20, ok);  chk("t6_req1", ok, 1);
      e0 = en_cnt;
      reset = 1'b1;
      cyc();
      force_ack = 1'b1;
      chk("t6_outputs_zero", {ir_out, ir_pc, mem_addr, pc_load_val, ir_valid, mem_req, pc_enable, pc_ld},
          32'h0);
      cyc();
      force_ack = 1'b0;
      chk("t6_ack_ignored", {ir_out, ir_pc, mem_addr, pc_load_val, ir_valid, mem_req, pc_enable, pc_ld},
          32'h0);
      reset = 1'b0;
      wait_req_rise(20, ok);  chk("t6_req_seen", ok, 1);
      chk("t6_pc", pc, 8'h00);
      chk("t6_restart_addr", mem_addr, 8'h00);
      chk("t6_no_enable", en_cnt - e0, 0);

      chk("inv_en_ld_exclusive", viol_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the 8-bit microprocessor, directly downstream of program_counter. Each cycle it may do one of three things:
- read the PC value and issue a request/acknowledge read to program memory;
- latch the returned byte into the instruction register and pulse pc_enable to advance the PC;
- hand the instruction to the decoder through a valid/ready handshake.
Jump requests from the decoder drive the PC's ld/inp ports and flush any in-flight or held fetch.

Parameters:
ADDR_W, 8, program address width; matches program_counter out/inp.
DATA_W, 8, instruction word width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; the only reset.
pc_in  in  ADDR_W  current PC value, from program_counter out.
pc_enable  out  1  one-cycle increment pulse to program_counter.
pc_ld  out  1  one-cycle load pulse to program_counter ld.
pc_load_val  out  ADDR_W  load value to program_counter inp.
mem_addr  out  ADDR_W  program memory address.
mem_req  out  1  memory read request.
mem_ack  in  1  memory acknowledge; mem_data is valid in the same cycle.
mem_data  in  DATA_W  memory read data.
ir_out  out  DATA_W  fetched instruction.
ir_pc  out  ADDR_W  address ir_out was fetched from.
ir_valid  out  1  instruction available to decoder.
ir_ready  in  1  decoder accepts instruction.
jump_req  in  1  one-cycle jump/branch request from decoder.
jump_addr  in  ADDR_W  jump target.
halt  in  1  level; blocks launch of new fetches.

Behaviour:
- Registers and outputs:
  - All outputs are registered.
  - On reset, every output is 0, state is IDLE, and the flush flag is 0.
  - reset overrides every other input in that cycle.
- States:
  - IDLE: go to REQ on the next edge if halt=0. mem_ack is ignored.
  - REQ: mem_addr<=pc_in, mem_req<=1, go to WAIT.
  - WAIT: mem_req and mem_addr are held stable until mem_ack=1 is sampled. On ack: mem_req<=0, then:
    - if flush=0: ir_out<=mem_data, ir_pc<=mem_addr, ir_valid<=1, pc_enable<=1 for one cycle, go to HOLD;
    - if flush=1: discard the data, clear flush, no pc_enable, go to IDLE.
  - HOLD: ir_out/ir_pc/ir_valid are held until ir_ready=1. Then ir_valid<=0 and go to REQ (halt=0) or IDLE (halt=1).
- Handshake timing:
  - Memory may ack in the first cycle mem_req is visible.
  - Minimum latency is 1 cycle from ack to ir_valid.
  - Steady-state throughput is 1 instruction per 3 cycles.
  - The pc_enable pulse lands before REQ re-samples pc_in, so the next fetch address is always PC+1.
- Jump (sampled in any state; highest priority after reset):
  - pc_ld<=1 and pc_load_val<=jump_addr for exactly one cycle; pc_enable<=0 in that cycle.
  - IDLE/REQ/HOLD: ir_valid<=0, go to IDLE. The IDLE bubble guarantees the loaded PC is visible before REQ samples it.
  - REQ: no mem_req is issued.
  - WAIT: mem_req stays held (no request is abandoned) and flush<=1. The ack is then consumed silently and the unit goes to IDLE.
  - jump_req with mem_ack in the same cycle: the jump wins. Data is dropped, no pc_enable, go to IDLE.
  - jump_req with ir_ready in the same HOLD cycle: the instruction counts as accepted; the jump still applies.
  - A second jump_req while flush=1 only updates pc_load_val/pc_ld; flush stays 1.
- Halt:
  - A fetch already in flight completes normally.
  - No new REQ is entered while halt=1.
  - Fetching resumes from IDLE the cycle after halt drops.
- Invariants:
  - pc_enable and pc_ld are never 1 in the same cycle.
  - pc_enable fires exactly once per delivered instruction.
  - ir_valid never rises while flush=1.
- Wrap-around: PC wrap (0xFF to 0x00) is owned by program_counter. Fetch from 0xFF is ordinary, and the next fetch is from 0x00.

Decomposition:
- fetch_pkg: state enum {IDLE, REQ, WAIT, HOLD} as a 2-bit localparam encoding, plus ADDR_W/DATA_W defaults.
- No sub-module: the FSM, IR register and flush flag are a single module.
- Bench instantiates fetch_unit with program_counter and a behavioural ROM with programmable ack latency.

Test Plan:
- Reset held 2 cycles then released, ROM[0x00]=0xA5, ack latency 2, ir_ready=1 -> ir_out=0xA5, ir_pc=0x00, one pc_enable pulse; next mem_addr=0x01.
- ROM 0x00..0x03 = 0x10,0x11,0x12,0x13, ack latency 0, ir_ready held 0 for 4 cycles after first ir_valid -> ir_out stays 0x10 and no new mem_req; after ready, sequence 0x11,0x12,0x13 follows with ir_pc 0x01..0x03.
- jump_req with jump_addr=0x18 while in WAIT at PC 0x02 -> pc_ld pulse with pc_load_val=0x18; ack for 0x02 dropped (no ir_valid, no pc_enable); next mem_addr=0x18.
- jump_req coincident with mem_ack -> no ir_valid, no pc_enable; PC=0x18; next fetch from 0x18.
- halt=1 asserted during WAIT -> that instruction delivered, then mem_req stays 0 for 5 cycles; halt=0 -> fetch resumes at PC+1.
- reset asserted mid-WAIT with mem_ack arriving one cycle later -> all outputs 0, ack ignored; after reset release, PC=0x00 and fetch restarts at 0x00.
